// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter.
//   uart_state_e : transmitter FSM states (3-bit encoding, shared with the receiver)
//   DefaultClkFreq / DefaultBaudRate : default clock and line rate
//   calc_div     : clocks per bit period (CLK_FREQ / BAUD_RATE, integer, must be >= 2)
// Optional feature macro: UART_TX_PARITY_EN (only the StParity encoding lives here).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned DefaultClkFreq  = 12_000_000;
  localparam int unsigned DefaultBaudRate = 9600;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  count enable; counter is held at 0 while low
//   tick out high on the last clock of each bit period (counter == DIV-1)
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DefaultClkFreq,
  parameter int unsigned BAUD_RATE = DefaultBaudRate
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == CntMax)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, LSB first, one stop bit.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   data  in   byte to send, captured on the valid && ready cycle
//   valid in   data holds a byte to send
//   ready out  idle, can accept a byte
//   busy  out  frame in progress (~ready)
//   done  out  one-cycle pulse after the stop bit completes
//   tx    out  registered serial line, idle high
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DefaultClkFreq,
  parameter int unsigned BAUD_RATE = DefaultBaudRate
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  uart_state_e r_state, w_state_d;
  logic [7:0]  r_shift, w_shift_d;
  logic [2:0]  r_bit_idx, w_bit_idx_d;
  logic        r_tx, w_tx_d;
  logic        r_done, w_done_d;
  logic        w_tick;
  logic        w_baud_en;
`ifdef UART_TX_PARITY_EN
  logic        r_parity, w_parity_d;
`endif

  assign w_baud_en = (r_state != StIdle);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_baud_en),
    .tick (w_tick)
  );

  // tx is computed one clock ahead so the registered line changes on the same
  // edge as the state it belongs to.
  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_idx_d = r_bit_idx;
    w_tx_d      = r_tx;
    w_done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_d  = r_parity;
`endif
    case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (valid) begin
          w_state_d   = StStart;
          w_shift_d   = data;
          w_bit_idx_d = 3'd0;
          w_tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_d  = ^data;
`endif
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_tx_d    = r_shift[0];
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d   = {1'b0, r_shift[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
            w_tx_d    = r_parity;
`else
            w_state_d = StStop;
            w_tx_d    = 1'b1;
`endif
          end else begin
            w_tx_d = w_shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_tick) begin
          w_state_d = StStop;
          w_tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
          w_tx_d    = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_idx <= w_bit_idx_d;
      r_tx      <= w_tx_d;
      r_done    <= w_done_d;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_d;
`endif
    end
  end

  assign ready = (r_state == StIdle);
  assign busy  = !ready;
  assign done  = r_done;
  assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. The clock is scaled (1.2 MHz at 9600 baud,
// DIV = 125) so the whole run stays short; idle and mid-frame offsets are
// scaled by the same factor.
module tb_uart_tx;

  localparam int unsigned ClkFreq  = 1_200_000;
  localparam int unsigned BaudRate = 9600;
  localparam int          Div      = 125;
`ifdef UART_TX_PARITY_EN
  localparam int          NBits    = 11;
`else
  localparam int          NBits    = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       tx;

  int total;
  int bad;

  uart_tx #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (BaudRate)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame = {stop, data[7:0], start}; par = even parity of data
  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
    logic       par;
    bit         hold;
  } vec_t;

  vec_t tab[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [10:0] mk_exp(input logic [9:0] frame, input logic par);
    logic [10:0] e;
`ifdef UART_TX_PARITY_EN
    e = {1'b1, par, frame[8:0]};
`else
    e = {par & 1'b0, frame};
`endif
    return e;
  endfunction

  // Entered just after a negedge with valid=1 and data=d already driven.
  // Checks every clock of the frame, then the done/ready cycle.
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input bit hold,
                           input logic [7:0] next_d, input int glitch_at);
    int errs;
    int st_errs;
    int cyc;
    chk($sformatf("ready before %02h", d), {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1;
    valid = hold;
    data  = hold ? next_d : ~d;
    cyc = 0;
    st_errs = 0;
    for (int b = 0; b < NBits; b++) begin
      errs = 0;
      for (int c = 0; c < Div; c++) begin
        @(negedge clk);
        cyc++;
        if (tx !== exp[b]) errs++;
        if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) st_errs++;
        if (glitch_at > 0 && cyc == glitch_at) begin
          valid = 1'b1;
          data  = 8'hFF;
        end else if (glitch_at > 0 && cyc == glitch_at + 1) begin
          valid = 1'b0;
          data  = 8'h00;
        end
      end
      chk($sformatf("frame %02h bit%0d bad cycles", d, b), errs, 0);
    end
    chk($sformatf("frame %02h status bad cycles", d), st_errs, 0);
    @(negedge clk);
    chk($sformatf("frame %02h end {done,ready,busy,tx}", d),
        {28'b0, done, ready, busy, tx}, 32'hD);
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("frame %02h after {done,ready,busy,tx}", d),
          {28'b0, done, ready, busy, tx}, 32'h5);
    end
  endtask

  initial begin
    int errs;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;

    tab[0] = '{d: 8'h55, frame: 10'b1_01010101_0, par: 1'b0, hold: 1'b0};
    tab[1] = '{d: 8'hA5, frame: 10'b1_10100101_0, par: 1'b0, hold: 1'b1};
    tab[2] = '{d: 8'h3C, frame: 10'b1_00111100_0, par: 1'b0, hold: 1'b0};
    tab[3] = '{d: 8'h07, frame: 10'b1_00000111_0, par: 1'b1, hold: 1'b0};
    tab[4] = '{d: 8'h03, frame: 10'b1_00000011_0, par: 1'b0, hold: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset {done,ready,busy,tx}", {28'b0, done, ready, busy, tx}, 32'h5);
    rst = 1'b0;

    // Long idle: line stays high, no done pulse.
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    chk("idle bad cycles", errs, 0);

    // Table-driven frames; a held entry chains straight into the next one.
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || !tab[i-1].hold) begin
        valid = 1'b1;
        data  = tab[i].d;
      end
      run_frame(tab[i].d, mk_exp(tab[i].frame, tab[i].par), tab[i].hold,
                (i < 4) ? tab[i+1].d : 8'h00, 0);
    end

    // 0x00 frame with a 0xFF valid pulse part way through: must be ignored.
    valid = 1'b1;
    data  = 8'h00;
    run_frame(8'h00, mk_exp(10'b1_00000000_0, 1'b0), 1'b0, 8'h00, 300);

    // Reset during data bit 2 of 0xF0 (line low), then a clean 0x81 frame.
    valid = 1'b1;
    data  = 8'hF0;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (400) @(negedge clk);
    chk("tx low before reset", {31'b0, tx}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset {done,ready,busy,tx}", {28'b0, done, ready, busy, tx}, 32'h5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 3 * Div; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) errs++;
    end
    chk("post-reset idle bad cycles", errs, 0);
    valid = 1'b1;
    data  = 8'h81;
    run_frame(8'h81, mk_exp(10'b1_10000001_0, 1'b0), 1'b0, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
